// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with configurable frame format and an input FIFO
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 12_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [1:0]                    parity_mode,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int BAUD_CYCLES = CLK_FREQ / BAUD;
   localparam int CW = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_BITS);
   localparam int EW = DATA_BITS + 2;
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [EW-1:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 push, pop, baud_end, stop_last;
   logic [EW-1:0]        head;

   state_t               state;
   logic [CW-1:0]        baud_cnt;
   logic [BW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, par_en;

   assign tx_ready   = (count != FULL);
   assign push       = tx_valid && tx_ready;
   assign baud_end   = (baud_cnt == CW'(BAUD_CYCLES - 1));
   assign stop_last  = (stop_idx == 1'(STOP_BITS - 1));
   assign pop        = (count != '0) &&
                       (state == IDLE || (state == STOP && baud_end && stop_last));
   assign head       = mem[rd_ptr];
   assign tx_busy    = (state != IDLE) || (count != '0);
   assign fifo_count = count;

   // Storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {parity_mode, data_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= tx_valid && !tx_ready;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         tx_out   <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         par_en   <= 1'b0;
      end else begin
         case (state)
            IDLE: tx_out <= 1'b1;
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  tx_out   <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == BW'(DATA_BITS - 1)) begin
                     stop_idx <= 1'b0;
                     state    <= par_en ? PARITY : STOP;
                     tx_out   <= par_en ? par_bit : 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= shreg >> 1;
                     tx_out  <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  stop_idx <= 1'b0;
                  state    <= STOP;
                  tx_out   <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (stop_last) begin
                     state  <= IDLE;
                     tx_out <= 1'b1;
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_out <= 1'b1;
            end
         endcase
         // A pop overrides the IDLE/STOP decisions above so frames chain with no gap.
         if (pop) begin
            shreg    <= head[DATA_BITS-1:0];
            par_en   <= head[DATA_BITS+1] ^ head[DATA_BITS];
            par_bit  <= (head[DATA_BITS+1:DATA_BITS] == 2'b01) ? ~^head[DATA_BITS-1:0]
                                                               :  ^head[DATA_BITS-1:0];
            baud_cnt <= '0;
            state    <= START;
            tx_out   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic       clk, rst_n;
   logic [7:0] din;
   logic [1:0] pm;
   logic       va, vb, vc;

   logic       rdy_a, tx_a, busy_a, ovf_a;
   logic [2:0] cnt_a;
   logic       rdy_b, tx_b, busy_b, ovf_b;
   logic [2:0] cnt_b;
   logic       rdy_c, tx_c, busy_c, ovf_c;
   logic [2:0] cnt_c;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_fifo dut_a (
      .clk(clk), .reset_n(rst_n), .data_in(din), .tx_valid(va), .tx_ready(rdy_a),
      .parity_mode(pm), .tx_out(tx_a), .tx_busy(busy_a), .fifo_count(cnt_a), .overflow(ovf_a)
   );

   // 120 kHz / 9600 gives 12 clocks per bit, keeping the longer scenarios short.
   uart_tx_fifo #(.CLK_FREQ(120_000)) dut_b (
      .clk(clk), .reset_n(rst_n), .data_in(din), .tx_valid(vb), .tx_ready(rdy_b),
      .parity_mode(pm), .tx_out(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b), .overflow(ovf_b)
   );

   uart_tx_fifo #(.CLK_FREQ(120_000), .DATA_BITS(7), .STOP_BITS(2)) dut_c (
      .clk(clk), .reset_n(rst_n), .data_in(din[6:0]), .tx_valid(vc), .tx_ready(rdy_c),
      .parity_mode(pm), .tx_out(tx_c), .tx_busy(busy_c), .fifo_count(cnt_c), .overflow(ovf_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic tx_of(input int w);
      case (w)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic busy_of(input int w);
      case (w)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   task automatic push(input int w, input logic [7:0] d, input logic [1:0] m);
      @(negedge clk);
      din = d;
      pm  = m;
      if (w == 0) va = 1'b1;
      else if (w == 1) vb = 1'b1;
      else vc = 1'b1;
      @(negedge clk);
      va = 1'b0; vb = 1'b0; vc = 1'b0;
      pm = 2'b00;
   endtask

   // bits[i] is the i-th bit on the line; every clock of every bit is compared.
   task automatic expect_frame(input string tag, input int w, input logic [15:0] bits,
                               input int nbits, input int bc, input int limit);
      bit found = 0;
      int errs  = 0;
      for (int i = 0; i < limit && !found; i++) begin
         @(negedge clk);
         if (tx_of(w) == 1'b0) found = 1;
      end
      if (!found) begin
         check({tag, "_start"}, 32'd0, 32'd1);
      end else begin
         for (int s = 0; s < nbits * bc; s++) begin
            if (s > 0) @(negedge clk);
            if (tx_of(w) !== bits[s / bc] || busy_of(w) !== 1'b1) errs++;
         end
         check(tag, errs, 0);
      end
   endtask

   logic [7:0] ov_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   initial begin
      int errs;
      rst_n = 1'b0; din = '0; pm = 2'b00; va = 1'b0; vb = 1'b0; vc = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx",    tx_b,   1);
      check("rst_busy",  busy_b, 0);
      check("rst_ready", rdy_b,  1);
      check("rst_count", cnt_b,  0);
      check("rst_ovf",   ovf_b,  0);
      check("rst_tx_a",  tx_a,   1);
      rst_n = 1'b1;

      // Defaults: 0x41, 8N1, 1250 clocks per bit
      push(0, 8'h41, 2'b00);
      check("lat_count", cnt_a, 1);
      check("lat_tx",    tx_a,  1);
      expect_frame("frame_41", 0, {1'b1, 8'h41, 1'b0}, 10, 1250, 1);
      @(negedge clk);
      check("a_busy_end", busy_a, 0);
      check("a_tx_end",   tx_a,   1);

      // Parity: 0x62 has three ones
      push(1, 8'h62, 2'b10);
      expect_frame("even_62", 1, {1'b1, 1'b1, 8'h62, 1'b0}, 11, 12, 1);
      push(1, 8'h62, 2'b01);
      expect_frame("odd_62", 1, {1'b1, 1'b0, 8'h62, 1'b0}, 11, 12, 1);
      @(negedge clk);
      check("par_busy_end", busy_b, 0);

      // Back-to-back frames
      fork
         begin
            @(negedge clk); din = 8'h41; vb = 1'b1;
            @(negedge clk); din = 8'h62;
            @(negedge clk); din = 8'h34;
            @(negedge clk); vb = 1'b0;
         end
         begin
            expect_frame("b2b_41", 1, {1'b1, 8'h41, 1'b0}, 10, 12, 4);
            expect_frame("b2b_62", 1, {1'b1, 8'h62, 1'b0}, 10, 12, 1);
            expect_frame("b2b_34", 1, {1'b1, 8'h34, 1'b0}, 10, 12, 1);
         end
      join
      @(negedge clk);
      check("b2b_busy_end", busy_b, 0);

      // Overflow: valid held for six cycles into a depth-4 FIFO
      fork
         begin
            @(negedge clk); din = ov_data[0]; vb = 1'b1;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               if (k == 4) begin
                  check("full_count", cnt_b, 4);
                  check("full_ready", rdy_b, 0);
                  check("ovf_quiet",  ovf_b, 0);
               end
               if (k == 5) begin
                  check("ovf_pulse", ovf_b, 1);
                  check("ovf_count", cnt_b, 4);
               end
               if (k < 5) din = ov_data[k+1];
               else vb = 1'b0;
            end
            @(negedge clk);
            check("ovf_clear", ovf_b, 0);
         end
         begin
            expect_frame("ov_f0", 1, {1'b1, 8'h11, 1'b0}, 10, 12, 4);
            expect_frame("ov_f1", 1, {1'b1, 8'h22, 1'b0}, 10, 12, 1);
            expect_frame("ov_f2", 1, {1'b1, 8'h33, 1'b0}, 10, 12, 1);
            expect_frame("ov_f3", 1, {1'b1, 8'h44, 1'b0}, 10, 12, 1);
            expect_frame("ov_f4", 1, {1'b1, 8'h55, 1'b0}, 10, 12, 1);
         end
      join
      errs = 0;
      repeat (150) begin
         @(negedge clk);
         if (tx_b !== 1'b1 || busy_b !== 1'b0) errs++;
      end
      check("ov_no_sixth", errs, 0);

      // Reset during data bit 3 of the first of three queued frames
      @(negedge clk); din = 8'h41; vb = 1'b1;
      @(negedge clk); din = 8'h62;
      @(negedge clk); din = 8'h34;
      @(negedge clk); vb = 1'b0;
      repeat (52) @(negedge clk);
      check("pre_rst_tx",    tx_b,  0);
      check("pre_rst_count", cnt_b, 2);
      #2 rst_n = 1'b0;
      #1;
      check("async_tx",    tx_b,   1);
      check("async_count", cnt_b,  0);
      check("async_busy",  busy_b, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      errs = 0;
      repeat (300) begin
         @(negedge clk);
         if (tx_b !== 1'b1 || busy_b !== 1'b0) errs++;
      end
      check("post_rst_quiet", errs, 0);
      push(1, 8'h34, 2'b00);
      expect_frame("post_rst_34", 1, {1'b1, 8'h34, 1'b0}, 10, 12, 1);

      // 7 data bits, odd parity, two stop bits
      push(2, 8'h55, 2'b01);
      expect_frame("f7o2_55", 2, {2'b11, 1'b1, 7'h55, 1'b0}, 11, 12, 1);
      @(negedge clk);
      check("c_busy_end", busy_c, 0);
      check("c_tx_end",   tx_c,   1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
